seq_divider_8bit: RTL and testbench

Sequential 8-bit unsigned restoring divider. It is the inverse datapath to the lab's shift-add multiplier and uses the same board-level usage model: switches load the dividend, Execute divides by the switch value, and results show on registers and hex displays. It performs one shift-subtract bit step every two clocks. Quotient and remainder are held until the next operation.

---
 rtl/divider_pkg.sv | 39 +++
 rtl/div_control.sv | 52 +++++
 rtl/seq_divider_8bit.sv | 78 +++++++
 tb/tb_seq_divider_8bit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the 8-bit sequential restoring divider.
package divider_pkg;

  localparam int N = 8;

  typedef enum logic [4:0] {
    IDLE   = 5'd0,
    SHIFT0 = 5'd1,  SHIFT1 = 5'd2,  SHIFT2 = 5'd3,  SHIFT3 = 5'd4,
    SHIFT4 = 5'd5,  SHIFT5 = 5'd6,  SHIFT6 = 5'd7,  SHIFT7 = 5'd8,
    SUB0   = 5'd9,  SUB1   = 5'd10, SUB2   = 5'd11, SUB3   = 5'd12,
    SUB4   = 5'd13, SUB5   = 5'd14, SUB6   = 5'd15, SUB7   = 5'd16,
    HOLD   = 5'd17
  } state_t;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/div_control.sv
// Sequencer for the divider: IDLE, alternating SHIFT/SUB steps per bit, then HOLD until Execute drops.
module div_control
  import divider_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic execute,
  input  logic clr_load,
  input  logic sw_zero,
  output logic ld_q,
  output logic clr_r,
  output logic shift_en,
  output logic sub_en,
  output logic ld_d,
  output logic dz_set
);

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // SHIFTk and SUBk are 8 codes apart, so stepping is plain offset arithmetic
  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (execute) state_nxt = sw_zero ? HOLD : SHIFT0;
    end else if (state inside {[SHIFT0:SHIFT7]}) begin
      state_nxt = state_t'(state + 5'd8);
    end else if (state == SUB7) begin
      state_nxt = HOLD;
    end else if (state inside {[SUB0:SUB6]}) begin
      state_nxt = state_t'(state - 5'd7);
    end else if (state == HOLD) begin
      if (!execute) state_nxt = IDLE;
    end else begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    ld_d     = (state == IDLE) &&  execute && !sw_zero;
    dz_set   = (state == IDLE) &&  execute &&  sw_zero;
    ld_q     = (state == IDLE) && !execute &&  clr_load;
    clr_r    = ld_q || ld_d;
    shift_en = state inside {[SHIFT0:SHIFT7]};
    sub_en   = state inside {[SUB0:SUB7]};
  end

endmodule

// File: rtl/seq_divider_8bit.sv
// Sequential 8-bit unsigned restoring divider: Q/R/D datapath, subtractor and hex decode.
module seq_divider_8bit
  import divider_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic         ClearR_loadQ,
  input  logic         Execute,
  input  logic [N-1:0] SW,
  output logic [N-1:0] Qval,
  output logic [N-1:0] Rval,
  output logic [6:0]   QhexU,
  output logic [6:0]   QhexL,
  output logic [6:0]   RhexU,
  output logic [6:0]   RhexL,
  output logic         DivZero
);

  logic [N-1:0] q, d;
  logic [N:0]   r;
  logic [N+1:0] diff;
  logic         dz;
  logic         ld_q, clr_r, shift_en, sub_en, ld_d, dz_set;

  div_control u_ctrl (
    .clk      (Clk),
    .rst      (Reset),
    .execute  (Execute),
    .clr_load (ClearR_loadQ),
    .sw_zero  (SW == '0),
    .ld_q     (ld_q),
    .clr_r    (clr_r),
    .shift_en (shift_en),
    .sub_en   (sub_en),
    .ld_d     (ld_d),
    .dz_set   (dz_set)
  );

  // Top bit of the 10-bit difference is the borrow
  assign diff = {1'b0, r} - {2'b00, d};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q  <= '0;
      r  <= '0;
      d  <= '0;
      dz <= 1'b0;
    end else if (dz_set) begin
      dz <= 1'b1;
      q  <= '1;
      r  <= {1'b0, q};
    end else begin
      if (ld_d) d <= SW;
      if (clr_r) begin
        r  <= '0;
        dz <= 1'b0;
      end
      if (ld_q) q <= SW;
      if (shift_en) begin
        r <= {r[N-1:0], q[N-1]};
        q <= {q[N-2:0], 1'b0};
      end
      if (sub_en && !diff[N+1]) begin
        r    <= diff[N:0];
        q[0] <= 1'b1;
      end
    end
  end

  assign Qval    = q;
  assign Rval    = r[N-1:0];
  assign DivZero = dz;
  assign QhexU   = seg7(q[7:4]);
  assign QhexL   = seg7(q[3:0]);
  assign RhexU   = seg7(r[7:4]);
  assign RhexL   = seg7(r[3:0]);

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Randomized bench for seq_divider_8bit against a transaction-level division model.
module tb_seq_divider_8bit;

  logic       Clk = 1'b0;
  logic       Reset, ClearR_loadQ, Execute;
  logic [7:0] SW;
  logic [7:0] Qval, Rval;
  logic [6:0] QhexU, QhexL, RhexU, RhexL;
  logic       DivZero;

  int checks = 0;
  int errors = 0;

  seq_divider_8bit dut (
    .Clk(Clk), .Reset(Reset), .ClearR_loadQ(ClearR_loadQ), .Execute(Execute), .SW(SW),
    .Qval(Qval), .Rval(Rval), .QhexU(QhexU), .QhexL(QhexL), .RhexU(RhexU), .RhexL(RhexL),
    .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: 0 idle, 1 busy, 2 hold
  int         m_mode = 0;
  int         m_cnt = 0;
  logic [7:0] m_q = 0, m_r = 0, m_dvd = 0, m_dvs = 1;
  logic       m_dz = 0;
  bit         chk_en = 0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_q = 0; m_r = 0; m_dz = 0; m_mode = 0; m_cnt = 0;
    end else begin
      case (m_mode)
        0: begin
          if (Execute) begin
            if (SW == 8'h00) begin
              m_dz = 1; m_r = m_q; m_q = 8'hFF; m_mode = 2;
            end else begin
              m_dvd = m_q; m_dvs = SW; m_dz = 0; m_cnt = 16; m_mode = 1;
            end
          end else if (ClearR_loadQ) begin
            m_q = SW; m_r = 0; m_dz = 0;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_q = m_dvd / m_dvs;
            m_r = m_dvd % m_dvs;
            m_mode = 2;
          end
        end
        default: if (!Execute) m_mode = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are meaningful whenever no division is in flight
  always @(negedge Clk) begin
    if (chk_en && m_mode != 1) begin
      chk("Qval", Qval, m_q);
      chk("Rval", Rval, m_r);
      chk("DivZero", {7'b0, DivZero}, {7'b0, m_dz});
      chk("QhexU", {1'b0, QhexU}, {1'b0, seg_tab[m_q[7:4]]});
      chk("QhexL", {1'b0, QhexL}, {1'b0, seg_tab[m_q[3:0]]});
      chk("RhexU", {1'b0, RhexU}, {1'b0, seg_tab[m_r[7:4]]});
      chk("RhexL", {1'b0, RhexL}, {1'b0, seg_tab[m_r[3:0]]});
    end
  end

  task automatic do_load(input logic [7:0] v);
    ClearR_loadQ = 1; SW = v;
    @(negedge Clk);
    ClearR_loadQ = 0; SW = 8'($urandom);
  endtask

  // Leaves the DUT in HOLD with Execute high and final results visible
  task automatic do_div(input logic [7:0] dv, input bit both, input int extra_hold);
    Execute = 1; SW = dv; ClearR_loadQ = both;
    @(negedge Clk);
    if (dv != 8'h00) begin
      for (int i = 0; i < 15; i++) begin
        SW = 8'($urandom); ClearR_loadQ = 1'($urandom); Execute = 1'($urandom);
        @(negedge Clk);
      end
    end
    ClearR_loadQ = 0; Execute = 1;
    if (dv != 8'h00) @(negedge Clk);
    repeat (extra_hold) @(negedge Clk);
  endtask

  task automatic release_exec();
    Execute = 0;
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1; ClearR_loadQ = 0; Execute = 0; SW = 8'h00;
    repeat (3) @(negedge Clk);
    chk_en = 1;
    Reset = 0;
    chk("rst_Q", Qval, 8'h00);
    chk("rst_R", Rval, 8'h00);
    chk("rst_DZ", {7'b0, DivZero}, 8'h00);
    chk("rst_hex", {1'b0, QhexU}, 8'h40);

    do_load(8'h64);
    do_div(8'h07, 0, 0);
    chk("t1_Q", Qval, 8'h0E);
    chk("t1_R", Rval, 8'h02);
    chk("t1_DZ", {7'b0, DivZero}, 8'h00);
    chk("t1_QhexU", {1'b0, QhexU}, 8'h40);
    chk("t1_QhexL", {1'b0, QhexL}, 8'h06);
    chk("t1_RhexL", {1'b0, RhexL}, 8'h24);
    release_exec();

    do_div(8'h03, 0, 0);
    chk("chain_Q", Qval, 8'h04);
    chk("chain_R", Rval, 8'h02);
    release_exec();

    do_load(8'hFF);
    do_div(8'h01, 0, 0);
    chk("ff1_Q", Qval, 8'hFF);
    chk("ff1_R", Rval, 8'h00);
    release_exec();
    do_load(8'hFF);
    do_div(8'hFF, 0, 0);
    chk("ffff_Q", Qval, 8'h01);
    chk("ffff_R", Rval, 8'h00);
    release_exec();

    do_load(8'h05);
    do_div(8'h09, 0, 0);
    chk("small_Q", Qval, 8'h00);
    chk("small_R", Rval, 8'h05);
    repeat (40) @(negedge Clk);
    chk("hold_Q", Qval, 8'h00);
    chk("hold_R", Rval, 8'h05);
    release_exec();

    do_load(8'h37);
    do_div(8'h00, 0, 0);
    chk("dz_DZ", {7'b0, DivZero}, 8'h01);
    chk("dz_Q", Qval, 8'hFF);
    chk("dz_R", Rval, 8'h37);
    release_exec();

    // Execute wins over a simultaneous load
    do_load(8'h64);
    do_div(8'h0A, 1, 0);
    chk("prio_Q", Qval, 8'h0A);
    chk("prio_R", Rval, 8'h00);
    release_exec();

    // Reset part-way through a division
    do_load(8'h64);
    Execute = 1; SW = 8'h07;
    repeat (8) @(negedge Clk);
    Reset = 1;
    @(negedge Clk);
    Reset = 0; Execute = 0;
    chk("mid_rst_Q", Qval, 8'h00);
    chk("mid_rst_R", Rval, 8'h00);
    chk("mid_rst_DZ", {7'b0, DivZero}, 8'h00);
    do_load(8'h64);
    do_div(8'h07, 0, 0);
    chk("after_rst_Q", Qval, 8'h0E);
    chk("after_rst_R", Rval, 8'h02);
    release_exec();

    for (int n = 0; n < 40; n++) begin
      logic [7:0] dv;
      dv = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 3) != 0) do_load(8'($urandom));
      do_div(dv, 1'($urandom), $urandom_range(0, 3));
      release_exec();
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
